// File: rtl/cmp_arb_pkg.sv
// Shared definitions for the comparator-sharing arbiter: operand width, FSM
// state names, ID-width helper and result-flag bit positions.
package cmp_arb_pkg;

    localparam int W        = 8;
    localparam int NREQ_DEF = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CMP  = 2'd1,
        ST_DONE = 2'd2
    } arb_state_e;

    localparam int GT = 2;
    localparam int LT = 1;
    localparam int EQ = 0;

    function automatic int id_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/cmp_rr_arbiter.sv
// Combinational round-robin pick: first set request at or after rr_ptr,
// wrapping modulo NREQ.
module cmp_rr_arbiter
    import cmp_arb_pkg::*;
#(
    parameter int NREQ = NREQ_DEF,
    parameter int IDW  = id_width(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  rr_ptr,
    output logic [IDW-1:0]  gnt_id,
    output logic            any_req
);

    logic [NREQ-1:0] w_rot;
    logic [IDW:0]    w_off;
    logic [IDW:0]    w_sum;

    always_comb begin
        // Rotate so bit 0 is the requester at rr_ptr; lowest set bit wins.
        w_rot   = NREQ'({req, req} >> rr_ptr);
        w_off   = '0;
        any_req = |req;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (w_rot[i]) begin
                w_off = (IDW+1)'(i);
            end
        end
        w_sum = {1'b0, rr_ptr} + w_off;
        if (w_sum >= (IDW+1)'(NREQ)) begin
            w_sum = w_sum - (IDW+1)'(NREQ);
        end
        gnt_id = w_sum[IDW-1:0];
    end

endmodule

// File: rtl/eight_bit_comparator.sv
// Existing unsigned 8-bit magnitude comparator, purely combinational.
module eight_bit_comparator (
    input  logic [7:0] a,
    input  logic [7:0] b,
    output logic       gt,
    output logic       lt,
    output logic       eq
);

    assign gt = (a > b);
    assign lt = (a < b);
    assign eq = (a == b);

endmodule

// File: rtl/cmp_share_arbiter.sv
// Shares one eight_bit_comparator among NREQ requesters with round-robin grant.
// Optional CMP_ARB_LOCK_EN adds a per-requester lock that holds the pointer.
module cmp_share_arbiter
    import cmp_arb_pkg::*;
#(
    parameter int NREQ = NREQ_DEF,
    parameter int IDW  = id_width(NREQ)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NREQ-1:0]     req,
    input  logic [NREQ*W-1:0]   a_in,
    input  logic [NREQ*W-1:0]   b_in,
`ifdef CMP_ARB_LOCK_EN
    input  logic [NREQ-1:0]     lock,
`endif
    output logic [NREQ-1:0]     ack,
    output logic                res_valid,
    output logic [IDW-1:0]      res_id,
    output logic                greater,
    output logic                less,
    output logic                equal
);

    localparam logic [1:0] IDLE = ST_IDLE;
    localparam logic [1:0] CMP  = ST_CMP;
    localparam logic [1:0] DONE = ST_DONE;

    logic [1:0]      r_state;
    logic [IDW-1:0]  r_rr_ptr;
    logic [IDW-1:0]  r_gnt_id;
    logic [IDW-1:0]  r_res_id;
    logic [W-1:0]    r_op_a;
    logic [W-1:0]    r_op_b;
    logic [2:0]      r_cmp;
    logic [2:0]      r_flags;
    logic [NREQ-1:0] r_ack;
    logic [NREQ-1:0] r_mask;
    logic            r_res_valid;

    logic [NREQ-1:0] w_req_eff;
    logic [IDW-1:0]  w_gnt_id;
    logic            w_any_req;
    logic [W-1:0]    w_sel_a;
    logic [W-1:0]    w_sel_b;
    logic            w_gt;
    logic            w_lt;
    logic            w_eq;
    logic [NREQ-1:0] w_gnt_onehot;
    logic [IDW-1:0]  w_next_ptr;
    logic            w_lock_hit;

    // The just-acked requester still shows req during its ack cycle; ignore it
    // there so a client dropping req at the end of ack is not granted twice.
    assign w_req_eff    = req & ~r_mask;
    assign w_gnt_onehot = NREQ'(1) << r_gnt_id;

`ifdef CMP_ARB_LOCK_EN
    assign w_lock_hit = lock[r_gnt_id];
`else
    assign w_lock_hit = 1'b0;
`endif

    always_comb begin
        if (w_lock_hit) begin
            w_next_ptr = r_gnt_id;
        end else if (r_gnt_id == IDW'(NREQ - 1)) begin
            w_next_ptr = '0;
        end else begin
            w_next_ptr = r_gnt_id + 1'b1;
        end
    end

    always_comb begin
        w_sel_a = '0;
        w_sel_b = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_gnt_id == IDW'(i)) begin
                w_sel_a = a_in[i*W +: W];
                w_sel_b = b_in[i*W +: W];
            end
        end
    end

    cmp_rr_arbiter #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_rr (
        .req     (w_req_eff),
        .rr_ptr  (r_rr_ptr),
        .gnt_id  (w_gnt_id),
        .any_req (w_any_req)
    );

    eight_bit_comparator u_cmp (
        .a  (r_op_a),
        .b  (r_op_b),
        .gt (w_gt),
        .lt (w_lt),
        .eq (w_eq)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_rr_ptr    <= '0;
            r_gnt_id    <= '0;
            r_res_id    <= '0;
            r_op_a      <= '0;
            r_op_b      <= '0;
            r_cmp       <= '0;
            r_flags     <= '0;
            r_ack       <= '0;
            r_mask      <= '0;
            r_res_valid <= 1'b0;
        end else begin
            r_ack       <= '0;
            r_mask      <= '0;
            r_res_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_any_req) begin
                        r_gnt_id <= w_gnt_id;
                        r_op_a   <= w_sel_a;
                        r_op_b   <= w_sel_b;
                        r_state  <= CMP;
                    end
                end
                CMP: begin
                    r_cmp[GT] <= w_gt;
                    r_cmp[LT] <= w_lt;
                    r_cmp[EQ] <= w_eq;
                    r_state   <= DONE;
                end
                DONE: begin
                    // Output flags only move together with res_valid.
                    r_flags     <= r_cmp;
                    r_ack       <= w_gnt_onehot;
                    r_res_valid <= 1'b1;
                    r_res_id    <= r_gnt_id;
                    r_rr_ptr    <= w_next_ptr;
                    r_mask      <= w_lock_hit ? '0 : w_gnt_onehot;
                    r_state     <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign ack       = r_ack;
    assign res_valid = r_res_valid;
    assign res_id    = r_res_id;
    assign greater   = r_flags[GT];
    assign less      = r_flags[LT];
    assign equal     = r_flags[EQ];

endmodule

// File: tb/tb_cmp_share_arbiter.sv
// Bench for cmp_share_arbiter: directed scenarios plus random traffic against a
// transaction-level model (rr pick, 3-edge latency, arithmetic compare).
module tb_cmp_share_arbiter;
    import cmp_arb_pkg::*;

    localparam int N   = 4;
    localparam int IDW = 2;
    localparam logic [2:0] F_GT = 3'b100;
    localparam logic [2:0] F_LT = 3'b010;
    localparam logic [2:0] F_EQ = 3'b001;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [N-1:0]   req;
    logic [N*W-1:0] a_in;
    logic [N*W-1:0] b_in;
    logic [N-1:0]   lock;
    logic [N-1:0]   ack;
    logic           res_valid;
    logic [IDW-1:0] res_id;
    logic           greater, less, equal;

    always #5 clk = ~clk;

    cmp_share_arbiter #(.NREQ(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .a_in      (a_in),
        .b_in      (b_in),
`ifdef CMP_ARB_LOCK_EN
        .lock      (lock),
`endif
        .ack       (ack),
        .res_valid (res_valid),
        .res_id    (res_id),
        .greater   (greater),
        .less      (less),
        .equal     (equal)
    );

    int checks = 0;
    int errors = 0;

    logic [7:0]   av [N];
    logic [7:0]   bv [N];
    logic [N-1:0] reqv, hold, lockv;

    assign req  = reqv;
    assign lock = lockv;
    always_comb begin
        a_in = '0;
        b_in = '0;
        for (int i = 0; i < N; i++) begin
            a_in[i*W +: W] = av[i];
            b_in[i*W +: W] = bv[i];
        end
    end

    // Reference model state
    int           m_ptr, m_lat, m_gnt;
    logic [7:0]   m_a, m_b;
    logic [N-1:0] m_mask, drop_cur, drop_next;
    logic [N-1:0] e_ack;
    logic         e_valid, e_gt, e_lt, e_eq;
    logic [IDW-1:0] e_id;

    // What the DUT reported on each ack
    int         obs_id [$];
    logic [2:0] obs_fl [$];

    task automatic model_reset();
        m_ptr = 0; m_lat = 0; m_gnt = 0; m_a = '0; m_b = '0;
        m_mask = '0; drop_cur = '0; drop_next = '0;
        e_ack = '0; e_valid = 1'b0; e_id = '0;
        e_gt = 1'b0; e_lt = 1'b0; e_eq = 1'b0;
    endtask

    task automatic model_edge();
        logic [N-1:0] eff;
        bit found;
        e_ack   = '0;
        e_valid = 1'b0;
        if (m_lat == 0) begin
            eff    = reqv & ~m_mask;
            m_mask = '0;
            found  = 1'b0;
            for (int k = 0; k < N; k++) begin
                int c;
                c = (m_ptr + k) % N;
                if (!found && eff[c]) begin
                    found = 1'b1;
                    m_gnt = c;
                end
            end
            if (found) begin
                m_a   = av[m_gnt];
                m_b   = bv[m_gnt];
                m_lat = 2;
            end
        end else begin
            m_lat--;
            if (m_lat == 0) begin
                e_ack   = N'(1) << m_gnt;
                e_valid = 1'b1;
                e_id    = IDW'(m_gnt);
                e_gt    = (m_a > m_b);
                e_lt    = (m_a < m_b);
                e_eq    = (m_a == m_b);
                if (lockv[m_gnt]) begin
                    m_ptr  = m_gnt;
                    m_mask = '0;
                end else begin
                    m_ptr  = (m_gnt + 1) % N;
                    m_mask = e_ack;
                end
                if (!hold[m_gnt]) drop_next = drop_next | e_ack;
            end
        end
    endtask

    task automatic check_outputs();
        checks++;
        assert (ack === e_ack) else begin
            errors++; $error("FAIL ack got %b exp %b t=%0t", ack, e_ack, $time);
        end
        checks++;
        assert (res_valid === e_valid) else begin
            errors++; $error("FAIL res_valid got %b exp %b t=%0t", res_valid, e_valid, $time);
        end
        checks++;
        assert ({greater, less, equal} === {e_gt, e_lt, e_eq}) else begin
            errors++;
            $error("FAIL flags got %b exp %b t=%0t", {greater, less, equal}, {e_gt, e_lt, e_eq}, $time);
        end
        if (e_valid) begin
            checks++;
            assert (res_id === e_id) else begin
                errors++; $error("FAIL res_id got %0d exp %0d t=%0t", res_id, e_id, $time);
            end
        end
        if (ack !== '0) begin
            obs_id.push_back(int'(res_id));
            obs_fl.push_back({greater, less, equal});
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        reqv      = reqv & ~drop_cur;
        drop_cur  = drop_next;
        drop_next = '0;
        @(negedge clk);
        check_outputs();
    endtask

    // Called at a negedge; releases at the following negedge.
    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        #1;
        check_outputs();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic check_id(input string tag, input int got, input int exp);
        checks++;
        assert (got === exp) else begin
            errors++; $error("FAIL %s got %0d exp %0d", tag, got, exp);
        end
    endtask

    task automatic check_fl(input string tag, input logic [2:0] got, input logic [2:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++; $error("FAIL %s got %b exp %b", tag, got, exp);
        end
    endtask

    int first_ack;
    int base;

    initial begin
        reqv = '0; hold = '0; lockv = '0;
        for (int i = 0; i < N; i++) begin av[i] = '0; bv[i] = '0; end
        rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        check_outputs();
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Single request, equal operands, latency
        av[2] = 8'd100; bv[2] = 8'd100; reqv[2] = 1'b1;
        first_ack = 0;
        base = obs_id.size();
        for (int t = 1; t <= 6; t++) begin
            tick();
            if (ack[2] && first_ack == 0) first_ack = t;
        end
        check_id("single_latency", first_ack, 3);
        check_id("single_id", (obs_id.size() > base) ? obs_id[base] : -1, 2);
        check_fl("single_flags", (obs_fl.size() > base) ? obs_fl[base] : 3'b000, F_EQ);

        // Four simultaneous requesters from pointer 0
        @(negedge clk);
        do_reset();
        av[0] = 8'd50;  bv[0] = 8'd60;
        av[1] = 8'd32;  bv[1] = 8'd31;
        av[2] = 8'd255; bv[2] = 8'd255;
        av[3] = 8'd0;   bv[3] = 8'd255;
        reqv = 4'hF;
        base = obs_id.size();
        for (int t = 0; t < 14; t++) tick();
        check_id("all4_count", obs_id.size() - base, 4);
        if (obs_id.size() >= base + 4) begin
            check_id("all4_g0", obs_id[base],     0);
            check_id("all4_g1", obs_id[base + 1], 1);
            check_id("all4_g2", obs_id[base + 2], 2);
            check_id("all4_g3", obs_id[base + 3], 3);
            check_fl("all4_f0", obs_fl[base],     F_LT);
            check_fl("all4_f1", obs_fl[base + 1], F_GT);
            check_fl("all4_f2", obs_fl[base + 2], F_EQ);
            check_fl("all4_f3", obs_fl[base + 3], F_LT);
        end

        // Fairness: 0 held, 3 pulsed
        do_reset();
        av[0] = 8'd7; bv[0] = 8'd9; av[3] = 8'd9; bv[3] = 8'd7;
        hold[0] = 1'b1; reqv[0] = 1'b1; reqv[3] = 1'b1;
        base = obs_id.size();
        for (int t = 0; t < 10; t++) tick();
        if (obs_id.size() >= base + 3) begin
            check_id("fair_first", obs_id[base], 0);
            check_id("fair_second", obs_id[base + 1], 3);
            check_id("fair_third", obs_id[base + 2], 0);
        end else begin
            check_id("fair_count", obs_id.size() - base, 3);
        end
        hold[0] = 1'b0; reqv[0] = 1'b0;
        for (int t = 0; t < 4; t++) tick();

        // Operand change after grant
        do_reset();
        av[1] = 8'd235; bv[1] = 8'd200; reqv[1] = 1'b1;
        base = obs_id.size();
        tick();
        tick();
        av[1] = 8'd10;
        for (int t = 0; t < 4; t++) tick();
        check_fl("opchg_flags", (obs_fl.size() > base) ? obs_fl[base] : 3'b000, F_GT);

        // Reset during CMP, req held through it
        av[0] = 8'd99; bv[0] = 8'd100; hold[0] = 1'b1; reqv[0] = 1'b1;
        tick();
        base = obs_id.size();
        do_reset();
        check_id("rst_no_ack", obs_id.size() - base, 0);
        for (int t = 0; t < 3; t++) tick();
        check_fl("rst_fresh_flags", (obs_fl.size() > base) ? obs_fl[base] : 3'b000, F_LT);
        hold[0] = 1'b0; reqv[0] = 1'b0;
        for (int t = 0; t < 4; t++) tick();

`ifdef CMP_ARB_LOCK_EN
        do_reset();
        av[1] = 8'd1; bv[1] = 8'd2; av[2] = 8'd3; bv[2] = 8'd3;
        lockv[1] = 1'b1; hold[1] = 1'b1; hold[2] = 1'b1; reqv = 4'b0110;
        base = obs_id.size();
        for (int t = 0; t < 4; t++) tick();
        lockv[1] = 1'b0;
        for (int t = 0; t < 6; t++) tick();
        if (obs_id.size() >= base + 3) begin
            check_id("lock_g0", obs_id[base],     1);
            check_id("lock_g1", obs_id[base + 1], 1);
            check_id("lock_g2", obs_id[base + 2], 2);
        end else begin
            check_id("lock_count", obs_id.size() - base, 3);
        end
        hold = '0; reqv = '0; lockv = '0;
        for (int t = 0; t < 4; t++) tick();
`endif

        // Random traffic against the model
        @(negedge clk);
        do_reset();
        for (int cyc = 0; cyc < 400; cyc++) begin
            for (int i = 0; i < N; i++) begin
                if (!reqv[i] && $urandom_range(0, 3) == 0) begin
                    av[i] = 8'($urandom);
                    bv[i] = ($urandom_range(0, 3) == 0) ? av[i] : 8'($urandom);
                    reqv[i] = 1'b1;
                end
            end
`ifdef CMP_ARB_LOCK_EN
            lockv = N'($urandom_range(0, 15)) & N'($urandom_range(0, 15));
`endif
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
